// File: rtl/cpu_pkg.sv
// Shared opcode, state and timing definitions for the RISC CPU main controller.
package cpu_pkg;

  localparam int unsigned OP_W         = 3;
  localparam int unsigned STATE_W      = 4;
  localparam int unsigned WAIT_MAX_DEF = 15;
  localparam int unsigned CNT_W_DEF    = 8;

  localparam logic [OP_W-1:0] OP_HLT  = 3'b000;
  localparam logic [OP_W-1:0] OP_SKZ  = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
  localparam logic [OP_W-1:0] OP_ANDD = 3'b011;
  localparam logic [OP_W-1:0] OP_XORR = 3'b100;
  localparam logic [OP_W-1:0] OP_LDA  = 3'b101;
  localparam logic [OP_W-1:0] OP_STO  = 3'b110;
  localparam logic [OP_W-1:0] OP_JMP  = 3'b111;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 4'd0,
    ST_S0     = 4'd1,
    ST_S1     = 4'd2,
    ST_S2     = 4'd3,
    ST_S3     = 4'd4,
    ST_S4     = 4'd5,
    ST_S5     = 4'd6,
    ST_S6     = 4'd7,
    ST_S7     = 4'd8,
    ST_HALTED = 4'd9
  } state_e;

  // Opcodes that read a data operand through the accumulator path.
  function automatic logic is_rd_op(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_ANDD) || (op == OP_XORR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Data-access wait-state counter; flags when the hold budget is used up.
module wait_timer #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) count <= '0;
    else if (inc)      count <= count + CNT_W'(1);
  end

  assign expired = (count == CNT_W'(WAIT_MAX));

endmodule

// File: rtl/cpu_sequencer.sv
// Main-control FSM: fetch (two IR bytes), decode, execute with data wait-states and timeout.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned WAIT_MAX = WAIT_MAX_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [OP_W-1:0]    opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               load_ir,
  output logic               inc_pc,
  output logic               load_pc,
  output logic               load_acc,
  output logic               rd,
  output logic               wr,
  output logic               datactl_ena,
  output logic               halt,
  output logic               bus_err,
  output logic [STATE_W-1:0] dbg_state
);

  state_e state, state_nxt;
  logic   bus_err_q, err_set;
  logic   access, timer_inc, timer_clr, expired;
  logic   load_ir_c, inc_pc_c, load_pc_c, load_acc_c, rd_c, wr_c, dctl_c, halt_c;

  wait_timer #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .inc     (timer_inc),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bus_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (err_set) bus_err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    load_ir_c  = 1'b0;
    inc_pc_c   = 1'b0;
    load_pc_c  = 1'b0;
    load_acc_c = 1'b0;
    rd_c       = 1'b0;
    wr_c       = 1'b0;
    dctl_c     = 1'b0;
    halt_c     = 1'b0;
    access     = 1'b0;
    err_set    = 1'b0;
    case (state)
      ST_IDLE: if (ena) state_nxt = ST_S0;
      ST_S0: begin
        load_ir_c = 1'b1; rd_c = 1'b1; inc_pc_c = 1'b1;
        state_nxt = ST_S1;
      end
      ST_S1: begin
        load_ir_c = 1'b1; rd_c = 1'b1; inc_pc_c = 1'b1;
        state_nxt = ST_S2;
      end
      ST_S2: state_nxt = ST_S3;
      ST_S3: state_nxt = (opcode == OP_HLT) ? ST_HALTED : ST_S4;
      ST_S4: begin
        state_nxt = ST_S5;
        if (is_rd_op(opcode)) begin
          rd_c = 1'b1; access = 1'b1;
        end else if (opcode == OP_STO) dctl_c = 1'b1;
        else if (opcode == OP_JMP)     load_pc_c = 1'b1;
        else if (opcode == OP_SKZ)     inc_pc_c = zero;
      end
      ST_S5: begin
        state_nxt = ST_S6;
        if (is_rd_op(opcode)) begin
          rd_c = 1'b1; load_acc_c = mem_ready; access = 1'b1;
        end else if (opcode == OP_STO) begin
          dctl_c = 1'b1; wr_c = 1'b1; access = 1'b1;
        end else if (opcode == OP_JMP) load_pc_c = 1'b1;
      end
      ST_S6: begin
        state_nxt = ST_S7;
        dctl_c    = (opcode == OP_STO);
      end
      ST_S7: begin
        inc_pc_c  = (opcode == OP_SKZ) && zero;
        state_nxt = ena ? ST_S0 : ST_IDLE;
      end
      ST_HALTED: halt_c = 1'b1;
      default:   state_nxt = ST_IDLE;
    endcase
    // Hold the data-access state until ready; a ready in the timeout cycle still wins.
    if (access && !mem_ready) begin
      if (expired) begin
        state_nxt = ST_HALTED;
        err_set   = 1'b1;
      end else begin
        state_nxt = state;
      end
    end
  end

  assign timer_inc = access && !mem_ready && !expired;
  assign timer_clr = !timer_inc;

  assign load_ir     = rst_n & load_ir_c;
  assign inc_pc      = rst_n & inc_pc_c;
  assign load_pc     = rst_n & load_pc_c;
  assign load_acc    = rst_n & load_acc_c;
  assign rd          = rst_n & rd_c;
  assign wr          = rst_n & wr_c;
  assign datactl_ena = rst_n & dctl_c;
  assign halt        = rst_n & halt_c;
  assign bus_err     = rst_n & bus_err_q;
  assign dbg_state   = rst_n ? state : '0;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, ena, zero, mem_ready;
  logic [2:0] opcode;
  logic       load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt, bus_err;
  logic [3:0] dbg_state;
  logic [8:0] outs;

  int checks   = 0;
  int failures = 0;
  int cyc, cnt, cnt2, hold;

  cpu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .load_ir(load_ir), .inc_pc(inc_pc), .load_pc(load_pc),
    .load_acc(load_acc), .rd(rd), .wr(wr), .datactl_ena(datactl_ena),
    .halt(halt), .bus_err(bus_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // {load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt, bus_err}
  assign outs = {load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt, bus_err};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [3:0] st, input logic [8:0] o);
    chk({tag, "_state"}, 32'(dbg_state), 32'(st));
    chk({tag, "_outs"}, 32'(outs), 32'(o));
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; zero = 1'b0; mem_ready = 1'b1; opcode = 3'b101;
    tick(); tick();
    chk_st("reset", 4'd0, 9'b0);

    // 1: LDA, zero-wait
    rst_n = 1'b1; ena = 1'b1; #1;
    chk_st("lda_idle", 4'd0, 9'b0);
    tick(); chk_st("lda_s0", 4'd1, 9'b110010000);
    tick(); chk_st("lda_s1", 4'd2, 9'b110010000);
    tick(); chk_st("lda_s2", 4'd3, 9'b0);
    tick(); chk_st("lda_s3", 4'd4, 9'b0);
    tick(); chk_st("lda_s4", 4'd5, 9'b000010000);
    tick(); chk_st("lda_s5", 4'd6, 9'b000110000);
    tick(); chk_st("lda_s6", 4'd7, 9'b0);
    tick(); chk_st("lda_s7", 4'd8, 9'b0);
    tick(); chk_st("lda_next_s0", 4'd1, 9'b110010000);

    // 2: SKZ with zero=1 then zero=0
    opcode = 3'b001; zero = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin cnt += int'(inc_pc); tick(); end
    chk("skz_z1_pulses", 32'(cnt), 32'd4);
    chk("skz_z1_back_s0", 32'(dbg_state), 32'd1);
    zero = 1'b0; #1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin cnt += int'(inc_pc); tick(); end
    chk("skz_z0_pulses", 32'(cnt), 32'd2);

    // 3: STO, three wait cycles in S5
    opcode = 3'b110; cyc = 0; cnt = 0; cnt2 = 0; hold = 0;
    do begin
      mem_ready = !(dbg_state == 4'd6 && hold < 3);
      if (dbg_state == 4'd6 && hold < 3) hold++;
      #1;
      cnt  += int'(wr);
      cnt2 += int'(datactl_ena);
      if (dbg_state == 4'd6) chk("sto_s5_outs", 32'(outs), 32'(9'b000001100));
      tick();
      cyc++;
    end while (dbg_state != 4'd1 && cyc < 40);
    mem_ready = 1'b1;
    chk("sto_cycles", 32'(cyc), 32'd11);
    chk("sto_wr_cycles", 32'(cnt), 32'd4);
    chk("sto_dctl_cycles", 32'(cnt2), 32'd6);

    // mem_ready in the timeout cycle wins
    opcode = 3'b010;
    tick(); tick(); tick(); tick();
    mem_ready = 1'b0; #1;
    for (int i = 0; i < 15; i++) tick();
    chk_st("race_last_hold", 4'd5, 9'b000010000);
    mem_ready = 1'b1; #1;
    tick(); chk_st("race_advance_s5", 4'd6, 9'b000110000);
    tick(); tick(); tick();
    chk("race_back_s0", 32'(dbg_state), 32'd1);

    // 4: ADD, mem_ready stuck low in S4
    mem_ready = 1'b0;
    tick(); tick(); tick(); tick();
    chk_st("to_first_hold", 4'd5, 9'b000010000);
    for (int i = 0; i < 15; i++) tick();
    chk("to_16th_hold", 32'(dbg_state), 32'd5);
    tick(); chk_st("to_halted", 4'd9, 9'b000000011);
    tick(); chk_st("to_halted_stays", 4'd9, 9'b000000011);
    rst_n = 1'b0; #1;
    chk_st("to_reset_forced", 4'd0, 9'b0);
    tick();
    rst_n = 1'b1; ena = 1'b0; mem_ready = 1'b1; #1;
    chk_st("to_reset_cleared", 4'd0, 9'b0);
    tick(); chk("idle_no_ena", 32'(dbg_state), 32'd0);

    // 5: HLT
    ena = 1'b1; opcode = 3'b000;
    tick(); tick(); tick(); tick();
    chk_st("hlt_s3", 4'd4, 9'b0);
    tick(); chk_st("hlt_halted", 4'd9, 9'b000000010);
    ena = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    chk_st("hlt_held", 4'd9, 9'b000000010);
    rst_n = 1'b0; #1;
    chk_st("hlt_reset_forced", 4'd0, 9'b0);
    tick(); rst_n = 1'b1; #1;
    chk_st("hlt_reset_idle", 4'd0, 9'b0);

    // 6: reset in S5 of STO
    ena = 1'b1; opcode = 3'b110;
    for (int i = 0; i < 6; i++) tick();
    chk_st("sto_mid_s5", 4'd6, 9'b000001100);
    rst_n = 1'b0; #1;
    chk("sto_reset_wr", 32'(wr), 32'd0);
    chk("sto_reset_outs", 32'(outs), 32'd0);
    tick(); rst_n = 1'b1; ena = 1'b0; #1;
    chk("sto_reset_idle", 32'(dbg_state), 32'd0);

    // JMP strobes, ena dropped mid-instruction ignored, ena=0 at S7 -> IDLE
    ena = 1'b1; opcode = 3'b111;
    tick(); tick(); ena = 1'b0; tick(); ena = 1'b1; tick();
    chk("jmp_s3_ena_ignored", 32'(dbg_state), 32'd4);
    tick(); chk_st("jmp_s4", 4'd5, 9'b001000000);
    tick(); chk_st("jmp_s5", 4'd6, 9'b001000000);
    tick(); tick();
    chk_st("jmp_s7", 4'd8, 9'b0);
    ena = 1'b0; #1;
    tick(); chk_st("s7_ena0_idle", 4'd0, 9'b0);
    tick(); chk("idle_stays", 32'(dbg_state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
